// File: rtl/AESDefinitions.sv
// AESDefinitions: shared AES round count, round-key types and key sequencer states
package AESDefinitions;
   localparam int NUM_ROUNDS = 10;
   typedef logic [127:0] roundKey_t;
   typedef roundKey_t [NUM_ROUNDS:0] roundKeys_t;
   typedef enum logic [1:0] {EMPTY, LOADED, SERVE} keySeqState_t;
endpackage

// File: rtl/round_key_sequencer.sv
// round_key_sequencer: stores an expanded AES key schedule and serves it one key per ack, forward or reverse
module round_key_sequencer
   import AESDefinitions::*;
#(
   parameter int NUM_ROUNDS = AESDefinitions::NUM_ROUNDS
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       loadValid,
   input  logic [NUM_ROUNDS:0][127:0] roundKeys,
   output logic                       loadReady,
   input  logic                       start,
   input  logic                       decrypt,
   input  logic                       abort,
   output logic                       keyValid,
   input  logic                       keyAck,
   output logic [127:0]               roundKey,
   output logic [3:0]                 roundIndex,
   output logic                       lastKey,
   output logic                       keyLoaded
);
   keySeqState_t state, nstate;
   logic [3:0]   idx, nidx;
   logic         dir, ndir, last, load;
   logic [127:0] keys [0:NUM_ROUNDS];
   assign load       = loadValid && loadReady;
   assign last       = dir ? idx == 4'd0 : idx == 4'(NUM_ROUNDS);
   assign loadReady  = state != SERVE;
   assign keyValid   = state == SERVE;
   assign keyLoaded  = state != EMPTY;
   assign lastKey    = keyValid && last;
   assign roundKey   = keyValid ? keys[idx] : '0;
   assign roundIndex = keyValid ? idx : '0;
   always_comb begin
      nstate = state;
      nidx   = idx;
      ndir   = dir;
      case (state)
         EMPTY:  if (loadValid) nstate = LOADED;
         LOADED: if (!loadValid && start) begin
            nstate = SERVE;
            nidx   = decrypt ? 4'(NUM_ROUNDS) : 4'd0;
            ndir   = decrypt;
         end
         SERVE:  if (abort || (keyAck && last)) nstate = LOADED;
                 else if (keyAck) nidx = dir ? idx - 4'd1 : idx + 4'd1;
         default: nstate = EMPTY;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
         idx   <= '0;
         dir   <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) keys[i] <= '0;
      end else begin
         state <= nstate;
         idx   <= nidx;
         dir   <= ndir;
         if (load) for (int i = 0; i <= NUM_ROUNDS; i++) keys[i] <= roundKeys[i];
      end
   end
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: directed FIPS-197 sequences, a vector table and a queue-model random run
module tb_round_key_sequencer;
   localparam int NR = 10;
   localparam bit H = 1'b1, L = 1'b0;
   typedef struct {
      bit st, dc, ak, ab, lv;
      bit kv;
      logic [3:0] ix;
      bit lk, lr;
   } vec_t;
   logic clock = 1'b0, reset_n = 1'b0;
   logic loadValid = 1'b0, start = 1'b0, decrypt = 1'b0, abort = 1'b0, keyAck = 1'b0;
   logic [NR:0][127:0] roundKeys = '0;
   logic loadReady, keyValid, lastKey, keyLoaded;
   logic [127:0] roundKey;
   logic [3:0] roundIndex;
   int passed = 0, total = 0;
   logic [NR:0][127:0] fpk, apk;
   logic [127:0] mk [0:NR];
   bit mLoaded;
   int q[$];
   vec_t tbl [0:20];
   always #5 clock = ~clock;
   round_key_sequencer #(.NUM_ROUNDS(NR)) dut (
      .clock(clock), .reset_n(reset_n), .loadValid(loadValid), .roundKeys(roundKeys),
      .loadReady(loadReady), .start(start), .decrypt(decrypt), .abort(abort),
      .keyValid(keyValid), .keyAck(keyAck), .roundKey(roundKey), .roundIndex(roundIndex),
      .lastKey(lastKey), .keyLoaded(keyLoaded)
   );
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction
   task automatic expand(input logic [127:0] key, output logic [NR:0][127:0] s);
      logic [31:0] w [0:4*NR+3];
      logic [31:0] t;
      logic [7:0] rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 4*NR+4; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask
   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask
   task automatic chkall(input string n, input logic kv, input logic [3:0] ix, input logic lk,
                         input logic lr, input logic kl, input logic [127:0] key);
      chk({n, ".keyValid"}, 128'(keyValid), 128'(kv));
      chk({n, ".roundIndex"}, 128'(roundIndex), 128'(ix));
      chk({n, ".lastKey"}, 128'(lastKey), 128'(lk));
      chk({n, ".loadReady"}, 128'(loadReady), 128'(lr));
      chk({n, ".keyLoaded"}, 128'(keyLoaded), 128'(kl));
      chk({n, ".roundKey"}, roundKey, key);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   function automatic vec_t v(bit st, bit dc, bit ak, bit ab, bit lv, bit kv, logic [3:0] ix, bit lk, bit lr);
      vec_t r;
      r.st = st; r.dc = dc; r.ak = ak; r.ab = ab; r.lv = lv;
      r.kv = kv; r.ix = ix; r.lk = lk; r.lr = lr;
      return r;
   endfunction
   initial begin
      expand(128'h000102030405060708090a0b0c0d0e0f, fpk);
      expand({$urandom, $urandom, $urandom, $urandom}, apk);
      tbl[0]  = v(H, L, H, L, L, H, 4'd0, L, L);
      tbl[1]  = v(L, L, H, L, L, H, 4'd1, L, L);
      tbl[2]  = v(L, L, H, L, L, H, 4'd2, L, L);
      tbl[3]  = v(L, L, H, L, L, H, 4'd3, L, L);
      for (int k = 4; k < 9; k++) tbl[k] = v(L, L, L, L, L, H, 4'd3, L, L);
      tbl[9]  = v(L, L, H, L, L, H, 4'd4, L, L);
      tbl[10] = v(L, L, H, L, L, H, 4'd5, L, L);
      tbl[11] = v(L, L, H, L, L, H, 4'd6, L, L);
      tbl[12] = v(L, L, H, H, L, L, 4'd0, L, H);
      tbl[13] = v(H, L, L, L, L, H, 4'd0, L, L);
      tbl[14] = v(L, L, L, L, H, H, 4'd0, L, L);
      tbl[15] = v(L, L, H, L, L, H, 4'd1, L, L);
      tbl[16] = v(L, L, L, H, L, L, 4'd0, L, H);
      tbl[17] = v(L, L, L, H, L, L, 4'd0, L, H);
      tbl[18] = v(L, L, H, L, L, L, 4'd0, L, H);
      tbl[19] = v(H, H, L, L, L, H, 4'd10, L, L);
      tbl[20] = v(L, L, L, H, L, L, 4'd0, L, H);
      #12;
      chkall("reset", L, 4'd0, L, H, L, '0);
      reset_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chkall("start_empty", L, 4'd0, L, H, L, '0);
      loadValid = 1'b1;
      roundKeys = fpk;
      tick();
      loadValid = 1'b0;
      chkall("loaded", L, 4'd0, L, H, H, '0);
      start = 1'b1;
      keyAck = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i <= NR; i++) begin
         chkall("enc", H, 4'(i), i == NR, L, H, fpk[i]);
         if (i == 0) chk("enc_fips_k0", roundKey, 128'h000102030405060708090a0b0c0d0e0f);
         if (i == NR) chk("enc_fips_k10", roundKey, 128'h13111d7fe3944a17f307a78b4d2b30c5);
         tick();
      end
      chkall("enc_done", L, 4'd0, L, H, H, '0);
      decrypt = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      decrypt = 1'b0;
      for (int i = 0; i <= NR; i++) begin
         chkall("dec", H, 4'(NR - i), i == NR, L, H, fpk[NR - i]);
         if (i == 0) chk("dec_fips_k10", roundKey, 128'h13111d7fe3944a17f307a78b4d2b30c5);
         tick();
      end
      chkall("dec_done", L, 4'd0, L, H, H, '0);
      keyAck = 1'b0;
      roundKeys = apk;
      for (int k = 0; k <= 20; k++) begin
         start = tbl[k].st; decrypt = tbl[k].dc; keyAck = tbl[k].ak;
         abort = tbl[k].ab; loadValid = tbl[k].lv;
         tick();
         start = 1'b0; decrypt = 1'b0; keyAck = 1'b0; abort = 1'b0; loadValid = 1'b0;
         chkall($sformatf("tbl%0d", k), tbl[k].kv, tbl[k].ix, tbl[k].lk, tbl[k].lr, H,
                tbl[k].kv ? fpk[tbl[k].ix] : 128'h0);
      end
      loadValid = 1'b1;
      start = 1'b1;
      tick();
      loadValid = 1'b0;
      start = 1'b0;
      chkall("load_start", L, 4'd0, L, H, H, '0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chkall("new_keys", H, 4'd0, L, L, H, apk[0]);
      keyAck = 1'b1;
      repeat (5) tick();
      keyAck = 1'b0;
      chkall("pre_reset", H, 4'd5, L, L, H, apk[5]);
      #3 reset_n = 1'b0;
      #1 chkall("async_reset", L, 4'd0, L, H, L, '0);
      #3 reset_n = 1'b1;
      tick();
      chkall("post_reset", L, 4'd0, L, H, L, '0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chkall("no_replay", L, 4'd0, L, H, L, '0);
      mLoaded = 1'b0;
      q.delete();
      for (int r = 0; r <= NR; r++) mk[r] = '0;
      repeat (3000) begin
         loadValid = ($urandom % 8) == 0;
         start     = ($urandom % 4) == 0;
         decrypt   = 1'($urandom % 2);
         abort     = ($urandom % 16) == 0;
         keyAck    = ($urandom % 3) != 0;
         if (loadValid) for (int r = 0; r <= NR; r++) roundKeys[r] = {$urandom, $urandom, $urandom, $urandom};
         if (q.size() > 0) begin
            if (abort) q.delete();
            else if (keyAck) void'(q.pop_front());
         end else if (loadValid) begin
            for (int r = 0; r <= NR; r++) mk[r] = roundKeys[r];
            mLoaded = 1'b1;
         end else if (start && mLoaded) begin
            for (int i = 0; i <= NR; i++) q.push_back(decrypt ? NR - i : i);
         end
         tick();
         chkall("rand", q.size() > 0, q.size() > 0 ? 4'(q[0]) : 4'd0, q.size() == 1,
                q.size() == 0, mLoaded, q.size() > 0 ? mk[q[0]] : 128'h0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
